// File: rtl/hazard_ctrl_if.sv
// Hazard controller port bundle: pipeline-side hazard inputs,
// freeze/flush controls and event counters.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             ID_EX_MemRead_in;
    logic [4:0]       ID_EX_RegisterRd_in;
    logic [4:0]       IF_ID_RegisterRs1_in;
    logic [4:0]       IF_ID_RegisterRs2_in;
    logic             Branch_taken_in;
    logic             halt_req_in;
    logic             resume_in;
    logic             PC_Write_out;
    logic             IF_ID_Write_out;
    logic             IF_ID_Flush_out;
    logic             ID_Flush_lwstall_out;
    logic             halted_out;
    logic [CNT_W-1:0] stall_cnt_out;
    logic [CNT_W-1:0] flush_cnt_out;

    modport master (
        output ID_EX_MemRead_in, ID_EX_RegisterRd_in,
        output IF_ID_RegisterRs1_in, IF_ID_RegisterRs2_in,
        output Branch_taken_in, halt_req_in, resume_in,
        input  PC_Write_out, IF_ID_Write_out, IF_ID_Flush_out,
        input  ID_Flush_lwstall_out, halted_out,
        input  stall_cnt_out, flush_cnt_out
    );

    modport slave (
        input  ID_EX_MemRead_in, ID_EX_RegisterRd_in,
        input  IF_ID_RegisterRs1_in, IF_ID_RegisterRs2_in,
        input  Branch_taken_in, halt_req_in, resume_in,
        output PC_Write_out, IF_ID_Write_out, IF_ID_Flush_out,
        output ID_Flush_lwstall_out, halted_out,
        output stall_cnt_out, flush_cnt_out
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use / branch hazard control with a drain-and-halt sequencer
// and saturating stall/flush event counters.
module hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input logic         clk,
    input logic         reset,
    hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } state_t;

    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

    state_t           state;
    logic [3:0]       drain_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             load_use;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             id_flush;
    logic             halted;

    assign load_use = hz.ID_EX_MemRead_in
                    & (hz.ID_EX_RegisterRd_in != 5'd0)
                    & ((hz.ID_EX_RegisterRd_in == hz.IF_ID_RegisterRs1_in)
                     | (hz.ID_EX_RegisterRd_in == hz.IF_ID_RegisterRs2_in));

    // Frozen pattern is the default: reset, DRAIN and HALTED all use it.
    always_comb begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        ifid_flush = 1'b1;
        id_flush   = 1'b1;
        halted     = 1'b0;
        if (!reset) begin
            unique case (state)
                RUN: begin
                    if (load_use) begin
                        ifid_flush = 1'b0;
                    end else begin
                        pc_write   = 1'b1;
                        ifid_write = 1'b1;
                        ifid_flush = hz.Branch_taken_in;
                        id_flush   = 1'b0;
                    end
                end
                HALTED: halted = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            drain_cnt <= 4'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (load_use) begin
                        if (stall_cnt != '1)
                            stall_cnt <= stall_cnt + CNT_W'(1);
                    end else begin
                        if (hz.Branch_taken_in && flush_cnt != '1)
                            flush_cnt <= flush_cnt + CNT_W'(1);
                        // A halt waiting behind a load-use stall lands here.
                        if (hz.halt_req_in) begin
                            state     <= DRAIN;
                            drain_cnt <= 4'd0;
                        end
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + 4'd1;
                    if (drain_cnt == DRAIN_LAST)
                        state <= HALTED;
                end
                HALTED: begin
                    if (hz.resume_in)
                        state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    assign hz.PC_Write_out         = pc_write;
    assign hz.IF_ID_Write_out      = ifid_write;
    assign hz.IF_ID_Flush_out      = ifid_flush;
    assign hz.ID_Flush_lwstall_out = id_flush;
    assign hz.halted_out           = halted;
    assign hz.stall_cnt_out        = stall_cnt;
    assign hz.flush_cnt_out        = flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table, directed
// halt/saturation sequences and a randomized run against a model.
module tb_hazard_ctrl;
    localparam int DC   = 3;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CW)) hz ();

    hazard_ctrl #(
        .DRAIN_CYCLES(DC),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .hz(hz.slave)
    );

    int checks = 0;
    int errors = 0;

    bit m_halted;
    int m_drain_left;
    int m_stall;
    int m_flush;

    typedef struct {
        bit mr;
        int rd;
        int r1;
        int r2;
        bit br;
        bit pc;
        bit ifw;
        bit fl;
        bit lw;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic drive(bit rs, bit mr, int rd, int r1, int r2,
                         bit br, bit hr, bit rsm);
        reset                   = rs;
        hz.ID_EX_MemRead_in     = mr;
        hz.ID_EX_RegisterRd_in  = 5'(rd);
        hz.IF_ID_RegisterRs1_in = 5'(r1);
        hz.IF_ID_RegisterRs2_in = 5'(r2);
        hz.Branch_taken_in      = br;
        hz.halt_req_in          = hr;
        hz.resume_in            = rsm;
        #1;
    endtask

    function automatic bit m_lu();
        int rd;
        rd = int'(hz.ID_EX_RegisterRd_in);
        return hz.ID_EX_MemRead_in && rd != 0 &&
               (rd == int'(hz.IF_ID_RegisterRs1_in) ||
                rd == int'(hz.IF_ID_RegisterRs2_in));
    endfunction

    function automatic int sat_inc(int v);
        return (v < CMAX) ? v + 1 : CMAX;
    endfunction

    // Compare every output against the model, then clock and advance it.
    task automatic step();
        bit frozen;
        bit lu;
        frozen = reset || m_halted || (m_drain_left > 0);
        lu     = m_lu();
        chk("pc_write",  hz.PC_Write_out,    32'(!frozen && !lu));
        chk("ifid_write", hz.IF_ID_Write_out, 32'(!frozen && !lu));
        chk("ifid_flush", hz.IF_ID_Flush_out,
            32'(frozen || (!lu && hz.Branch_taken_in)));
        chk("id_flush",  hz.ID_Flush_lwstall_out, 32'(frozen || lu));
        chk("halted",    hz.halted_out,  32'(!reset && m_halted));
        chk("stall_cnt", hz.stall_cnt_out, 32'(m_stall));
        chk("flush_cnt", hz.flush_cnt_out, 32'(m_flush));
        @(posedge clk);
        if (reset) begin
            m_halted     = 1'b0;
            m_drain_left = 0;
            m_stall      = 0;
            m_flush      = 0;
        end else if (m_halted) begin
            if (hz.resume_in) m_halted = 1'b0;
        end else if (m_drain_left > 0) begin
            m_drain_left--;
            if (m_drain_left == 0) m_halted = 1'b1;
        end else begin
            if (lu) m_stall = sat_inc(m_stall);
            else if (hz.Branch_taken_in) m_flush = sat_inc(m_flush);
            if (hz.halt_req_in && !lu) m_drain_left = DC;
        end
        #1;
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
    endtask

    initial begin
        int n;
        m_halted     = 1'b0;
        m_drain_left = 0;
        m_stall      = 0;
        m_flush      = 0;
        tbl[0] = '{1, 5, 5, 0, 0, 0, 0, 0, 1};
        tbl[1] = '{1, 0, 0, 0, 0, 1, 1, 0, 0};
        tbl[2] = '{0, 5, 5, 0, 0, 1, 1, 0, 0};
        tbl[3] = '{1, 7, 3, 7, 0, 0, 0, 0, 1};
        tbl[4] = '{1, 7, 3, 4, 1, 1, 1, 1, 0};
        tbl[5] = '{1, 9, 9, 1, 1, 0, 0, 0, 1};
        tbl[6] = '{0, 9, 9, 1, 1, 1, 1, 1, 0};
        tbl[7] = '{1, 31, 31, 31, 0, 0, 0, 0, 1};

        @(negedge clk);
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_stall_cnt", hz.stall_cnt_out, 0);
        chk("rst_pc_write", hz.PC_Write_out, 1);

        foreach (tbl[i]) begin
            drive(0, tbl[i].mr, tbl[i].rd, tbl[i].r1, tbl[i].r2,
                  tbl[i].br, 0, 0);
            chk($sformatf("tbl%0d_pc", i), hz.PC_Write_out, 32'(tbl[i].pc));
            chk($sformatf("tbl%0d_ifw", i), hz.IF_ID_Write_out,
                32'(tbl[i].ifw));
            chk($sformatf("tbl%0d_fl", i), hz.IF_ID_Flush_out,
                32'(tbl[i].fl));
            chk($sformatf("tbl%0d_lw", i), hz.ID_Flush_lwstall_out,
                32'(tbl[i].lw));
            step();
        end
        chk("tbl_stall_total", hz.stall_cnt_out, 4);
        chk("tbl_flush_total", hz.flush_cnt_out, 2);

        // One-cycle halt request, then drain, hold and resume.
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        step();
        for (int i = 0; i < DC; i++) begin
            drive(0, 0, 0, 0, 0, 1, 0, 1);
            chk("drain_pc", hz.PC_Write_out, 0);
            chk("drain_fl", hz.IF_ID_Flush_out, 1);
            chk("drain_halted", hz.halted_out, 0);
            step();
        end
        drive(0, 1, 4, 4, 0, 0, 1, 0);
        chk("halted_set", hz.halted_out, 1);
        chk("halted_stall", hz.stall_cnt_out, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("resume_pc", hz.PC_Write_out, 1);
        chk("resume_halted", hz.halted_out, 0);
        step();

        // Halt arriving during a load-use stall is deferred one cycle.
        do_reset();
        drive(0, 1, 6, 0, 6, 0, 1, 0);
        step();
        drive(0, 0, 6, 0, 6, 0, 1, 0);
        chk("defer_accept_pc", hz.PC_Write_out, 1);
        step();
        n = 0;
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0);
            if (hz.halted_out) break;
            n++;
            step();
        end
        chk("defer_drain_len", 32'(n), DC);

        // Stall counter saturation, then reset out of HALTED.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, 3, 3, 3, 0, 0, 0);
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("stall_sat", hz.stall_cnt_out, CMAX);
        drive(0, 0, 0, 0, 0, 1, 1, 0);
        step();
        for (int i = 0; i < DC; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0);
            step();
        end
        drive(1, 0, 0, 0, 0, 0, 0, 1);
        chk("rst_in_halt_halted", hz.halted_out, 0);
        chk("rst_in_halt_pc", hz.PC_Write_out, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("post_rst_pc", hz.PC_Write_out, 1);
        chk("post_rst_stall", hz.stall_cnt_out, 0);
        chk("post_rst_flush", hz.flush_cnt_out, 0);
        step();

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 99) == 0,
                  $urandom_range(0, 1),
                  $urandom_range(0, 3),
                  $urandom_range(0, 3),
                  $urandom_range(0, 3),
                  $urandom_range(0, 2) == 0,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 3) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: DRAIN_CYCLES, default 3, number of bubble cycles inserted after a halt request before halted_out asserts (1..15).
REQ-002 Parameter: CNT_W, default 16, width of the stall and flush event counters.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ID_EX_MemRead_in  in  1  instruction now in EX is a load.
REQ-006 ID_EX_RegisterRd_in  in  5  destination register of the instruction in EX.
REQ-007 IF_ID_RegisterRs1_in  in  5  rs1 of the instruction in ID.
REQ-008 IF_ID_RegisterRs2_in  in  5  rs2 of the instruction in ID.
REQ-009 Branch_taken_in  in  1  branch resolved taken in ID this cycle.
REQ-010 halt_req_in  in  1  request to drain and freeze the pipeline (level).
REQ-011 resume_in  in  1  request to leave HALTED (level).
REQ-012 PC_Write_out  out  1  PC register update enable.
REQ-013 IF_ID_Write_out  out  1  IF/ID register update enable.
REQ-014 IF_ID_Flush_out  out  1  IF/ID register clear to NOP.
REQ-015 ID_Flush_lwstall_out  out  1  ID/EX control-field clear (bubble insert).
REQ-016 halted_out  out  1  pipeline drained and frozen.
REQ-017 stall_cnt_out  out  CNT_W  count of load-use stall cycles.
REQ-018 flush_cnt_out  out  CNT_W  count of branch-taken flushes.

Function
REQ-019 load_use (combinational) = ID_EX_MemRead_in & (ID_EX_RegisterRd_in != 0) & (Rd == Rs1 | Rd == Rs2).
REQ-020 FSM states: RUN, DRAIN, HALTED; all outputs are combinational from the state and the current inputs, so they take effect at the very next rising edge.
REQ-021 RUN, load_use=1: PC_Write=0, IF_ID_Write=0, IF_ID_Flush=0, ID_Flush_lwstall=1; Branch_taken_in ignored this cycle.
REQ-022 RUN, load_use=0, Branch_taken_in=1: PC_Write=1, IF_ID_Write=1, IF_ID_Flush=1, ID_Flush_lwstall=0.
REQ-023 RUN, otherwise: PC_Write=1, IF_ID_Write=1, IF_ID_Flush=0, ID_Flush_lwstall=0.
REQ-024 RUN to DRAIN when halt_req_in=1 and load_use=0; the drain counter loads 0; the outputs in the accepting cycle follow REQ-022/023.
REQ-025 A halt_req_in that coincides with load_use=1 is deferred (the state stays RUN) until the first cycle with load_use=0, so the stalled dependent instruction is never lost.
REQ-026 DRAIN: PC_Write=0, IF_ID_Write=0, IF_ID_Flush=1, ID_Flush_lwstall=1; the drain counter increments each cycle; the state goes to HALTED on the edge where counter == DRAIN_CYCLES-1.
REQ-027 HALTED: same frozen outputs as DRAIN; halted_out=1 only in HALTED.
REQ-028 HALTED to RUN on the edge where resume_in=1; the first RUN cycle refetches the PC held since DRAIN entry.
REQ-029 resume_in is ignored in RUN and DRAIN; halt_req_in is ignored in DRAIN and HALTED.
REQ-030 stall_cnt_out increments by 1 on each RUN cycle with load_use=1 and saturates at all-ones.
REQ-031 flush_cnt_out increments by 1 on each RUN cycle with load_use=0 and Branch_taken_in=1, and saturates at all-ones.
REQ-032 The load_use and branch outputs and the counters are inactive in DRAIN and HALTED.

Reset
REQ-033 With reset=1 at a rising edge: state becomes RUN, the drain counter, stall_cnt_out and flush_cnt_out become 0.
REQ-034 While reset=1 (regardless of state or other inputs): PC_Write=0, IF_ID_Write=0, IF_ID_Flush=1, ID_Flush_lwstall=1, halted_out=0.
REQ-035 Reset asserted in DRAIN or HALTED aborts the sequence; the first cycle after deassertion is RUN with REQ-023 outputs.

Verification
REQ-036 Load-use: MemRead=1, Rd=5, Rs1=5, Rs2=0, one cycle -> PC_Write=0, IF_ID_Write=0, ID_Flush_lwstall=1; stall_cnt_out 0->1.
REQ-037 x0 dependence: MemRead=1, Rd=0, Rs1=0 -> no stall, PC_Write=1; stall_cnt_out unchanged.
REQ-038 Branch and load-use in the same cycle -> stall only; next cycle (load_use=0, Branch=1) -> IF_ID_Flush=1; flush_cnt_out=1.
REQ-039 Halt: halt_req one cycle in RUN, DRAIN_CYCLES=3 -> 3 DRAIN cycles with all freezes, then halted_out=1; resume_in -> RUN next cycle, PC_Write=1.
REQ-040 Halt during a load-use stall -> acceptance is delayed one cycle; halted_out rises DRAIN_CYCLES cycles after the deferred acceptance.
REQ-041 Counter saturation (CNT_W=4): 20 stall cycles -> stall_cnt_out=15; reset in HALTED -> RUN, counters 0, halted_out=0.
